// File: rtl/s2c_pkg.sv
// Shared types and constants for the sim-to-C call arbiter.
package s2c_pkg;

    typedef struct packed {
        logic [31:0] id;
        logic [31:0] fn;
        logic [31:0] addr;
        logic [31:0] size;
    } s2c_call_s;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } s2c_state_e;

    localparam logic [31:0] S2C_RET_TIMEOUT = 32'hFFFF_FFFF;

endpackage

// File: rtl/s2c_call_arb_if.sv
// Requester and downstream call-channel signals of the arbiter.
interface s2c_call_arb_if
    import s2c_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    s2c_call_s [NUM_REQ-1:0]       req_call;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            rsp_valid;
    logic [31:0]                   rsp_ret;
    logic                          rsp_err;
    logic                          call_valid;
    s2c_call_s                     call;
    logic                          call_ready;
    logic                          done_valid;
    logic [31:0]                   done_ret;
    logic                          busy;
    logic [IW-1:0]                 grant_idx;

    modport slave (
        input  req_valid, req_call, call_ready, done_valid, done_ret,
        output req_ready, rsp_valid, rsp_ret, rsp_err, call_valid, call, busy, grant_idx
    );

    modport master (
        output req_valid, req_call, call_ready, done_valid, done_ret,
        input  req_ready, rsp_valid, rsp_ret, rsp_err, call_valid, call, busy, grant_idx
    );

endinterface

// File: rtl/s2c_rr_pick.sv
// Round-robin picker: first requesting index after 'last', wrapping.
module s2c_rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [$clog2(NUM_REQ)-1:0] grant,
    output logic                       any
);
    localparam int unsigned IW = $clog2(NUM_REQ);

    int unsigned idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        any   = |req;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(last) + i) % NUM_REQ;
            if (!found && req[IW'(idx)]) begin
                found = 1'b1;
                grant = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/s2c_call_arb.sv
// Arbitrates NUM_REQ requesters onto a single outstanding sim-to-C call with timeout.
module s2c_call_arb
    import s2c_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned TIMEOUT = 1024
) (
    input logic           clk,
    input logic           rst,
    s2c_call_arb_if.slave bus
);
    localparam int unsigned   IW       = $clog2(NUM_REQ);
    localparam int unsigned   CW       = $clog2(TIMEOUT) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    s2c_state_e         state;
    logic [IW-1:0]      last_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_any;
    logic [CW-1:0]      cnt;
    logic [IW-1:0]      grant_idx;
    logic [NUM_REQ-1:0] grant_mask;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0] rsp_valid;
    logic [31:0]        rsp_ret;
    logic               rsp_err;
    logic               call_valid;
    s2c_call_s          call;
    logic               busy;

    s2c_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (bus.req_valid),
        .last  (last_grant),
        .grant (pick_idx),
        .any   (pick_any)
    );

    assign grant_mask = NUM_REQ'(1) << grant_idx;

    // Gated by rst so a request seen during reset is never acknowledged.
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && pick_any) req_ready[pick_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= IW'(NUM_REQ - 1);
            cnt        <= '0;
            grant_idx  <= '0;
            rsp_valid  <= '0;
            rsp_ret    <= '0;
            rsp_err    <= 1'b0;
            call_valid <= 1'b0;
            call       <= '0;
            busy       <= 1'b0;
        end else begin
            rsp_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        call       <= bus.req_call[pick_idx];
                        grant_idx  <= pick_idx;
                        call_valid <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.call_ready) begin
                        call_valid <= 1'b0;
                        cnt        <= '0;
                        state      <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != '1) cnt <= cnt + CW'(1);
                    // A completion arriving on the timeout cycle takes priority.
                    if (bus.done_valid) begin
                        rsp_ret   <= bus.done_ret;
                        rsp_err   <= 1'b0;
                        rsp_valid <= grant_mask;
                        state     <= RESP;
                    end else if (cnt >= CNT_LAST) begin
                        rsp_ret   <= S2C_RET_TIMEOUT;
                        rsp_err   <= 1'b1;
                        rsp_valid <= grant_mask;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    last_grant <= grant_idx;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.req_ready  = req_ready;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_ret    = rsp_ret;
    assign bus.rsp_err    = rsp_err;
    assign bus.call_valid = call_valid;
    assign bus.call       = call;
    assign bus.busy       = busy;
    assign bus.grant_idx  = grant_idx;

endmodule

// File: doc/s2c_call_arb.md
S2C_CALL_ARB -- requirements
Module: s2c_call_arb

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing the sim-to-C call channel (2..8).
REQ-002 Parameter TIMEOUT, default 1024: max cycles from downstream call acceptance to completion.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_valid  in  NUM_REQ  per-requester call request.
REQ-006 req_call  in  NUM_REQ x s2c_call_s  per-requester call descriptor {id, fn, addr, size}, 32 bits each.
REQ-007 req_ready  out  NUM_REQ  one-hot accept pulse; descriptor captured when valid & ready.
REQ-008 rsp_valid  out  NUM_REQ  one-hot completion pulse to the granted requester.
REQ-009 rsp_ret  out  32  return code of the completed call, valid with rsp_valid.
REQ-010 rsp_err  out  1  timeout flag, valid with rsp_valid.
REQ-011 call_valid  out  1  downstream call request.
REQ-012 call  out  s2c_call_s  latched descriptor, stable while call_valid.
REQ-013 call_ready  in  1  downstream accept.
REQ-014 done_valid  in  1  downstream completion pulse.
REQ-015 done_ret  in  32  downstream return code, valid with done_valid.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 grant_idx  out  clog2(NUM_REQ)  index of current/last granted requester.

Function
REQ-018 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; exactly one call outstanding at any time.
REQ-019 IDLE: if any req_valid, grant by round-robin starting at (last_grant+1) mod NUM_REQ, pulse req_ready[g] same cycle, latch req_call[g] and g, go ISSUE; else stay.
REQ-020 req_ready SHALL be combinational from req_valid and FSM state and never asserted outside IDLE.
REQ-021 ISSUE: call_valid=1 with latched descriptor; on call_ready go WAIT and clear timeout counter; call SHALL not change while call_valid.
REQ-022 WAIT: counter increments each cycle; done_valid latches done_ret, rsp_err=0, go RESP.
REQ-023 WAIT: counter reaching TIMEOUT-1 without done_valid sets ret=32'hFFFF_FFFF, rsp_err=1, go RESP.
REQ-024 done_valid and timeout in same cycle: done_valid wins.
REQ-025 done_valid outside WAIT SHALL be ignored (no state change, no response).
REQ-026 RESP: rsp_valid[g]=1 for exactly one cycle with rsp_ret/rsp_err, last_grant<=g, go IDLE.
REQ-027 Minimum latency request accept -> rsp_valid: 3 cycles (call_ready and done_valid each asserted on first opportunity).
REQ-028 Requester deasserting req_valid before grant SHALL lose no state; withdrawal after grant does not cancel the call.
REQ-029 Timeout counter SHALL be clog2(TIMEOUT)+1 bits, saturating, no wrap.

Reset
REQ-030 On rst: state IDLE, last_grant=NUM_REQ-1 (first grant favours requester 0), counter 0.
REQ-031 Reset values: req_ready 0, rsp_valid 0, rsp_ret 0, rsp_err 0, call_valid 0, call 0, busy 0, grant_idx 0.
REQ-032 rst mid-call SHALL abandon the call silently with no rsp_valid; subsequent done_valid ignored.

Structure
REQ-033 s2c_call_s, state enum and S2C_RET_TIMEOUT (32'hFFFF_FFFF) SHALL live in shared package s2c_pkg.
REQ-034 Round-robin picker SHALL be sub-module s2c_rr_pick (inputs req vector, last index; outputs grant index, any).

Verification
REQ-035 Single req: req_valid[2], id=5 fn=3 addr=0x100 size=4; call_ready and done_valid(ret=7) immediate -> rsp_valid[2] 3 cycles after accept, rsp_ret=7, rsp_err=0.
REQ-036 All 4 valid continuously after reset -> grant order 0,1,2,3,0; each gets one rsp_valid.
REQ-037 call_ready held low 10 cycles -> call_valid and call stable throughout; no req_ready pulses.
REQ-038 No done_valid with TIMEOUT=16 -> rsp_valid after 16 WAIT cycles, rsp_ret=0xFFFFFFFF, rsp_err=1.
REQ-039 done_valid and timeout same cycle -> rsp_err=0, rsp_ret=done_ret; stray done_valid in IDLE -> no response.
REQ-040 rst asserted in WAIT -> outputs at reset values next cycle; later done_valid produces no rsp_valid.
